// File: rtl/mips_ex_stage_if.sv
// Instruction/operand bus into the EX stage and its registered result/next-PC outputs.
interface mips_ex_stage_if;
  logic [31:0] Ins;
  logic [31:0] Rdata1;
  logic [31:0] Rdata2;
  logic [31:0] Ed32;
  logic [31:0] nextPC;
  logic [31:0] Result;
  logic [31:0] newPC;

  modport master (
    output Ins, Rdata1, Rdata2, Ed32, nextPC,
    input  Result, newPC
  );

  modport slave (
    input  Ins, Rdata1, Rdata2, Ed32, nextPC,
    output Result, newPC
  );
endinterface

// File: rtl/mips_ex_stage.sv
// MIPS execute stage: decode, ALU and next-PC selection, with Result/newPC registered once per cycle.
module mips_ex_stage (
  input  logic             CLK,
  input  logic             RST,
  mips_ex_stage_if.slave   bus
);

  localparam int unsigned W = 32;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_SLLV = 6'h04;
  localparam logic [5:0] FN_SRLV = 6'h06;
  localparam logic [5:0] FN_SRAV = 6'h07;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_JALR = 6'h09;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  logic [5:0]   opcode;
  logic [5:0]   funct;
  logic [4:0]   shamt;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] imm;
  logic [W-1:0] zimm;
  logic [W-1:0] br_target;
  logic [W-1:0] jmp_target;
  logic [W-1:0] result_c;
  logic [W-1:0] new_pc_c;

  assign opcode     = bus.Ins[31:26];
  assign funct      = bus.Ins[5:0];
  assign shamt      = bus.Ins[10:6];
  assign a          = bus.Rdata1;
  assign b          = bus.Rdata2;
  assign imm        = bus.Ed32;
  assign zimm       = {16'h0, bus.Ed32[15:0]};
  assign br_target  = bus.nextPC + (bus.Ed32 << 2);
  assign jmp_target = {bus.nextPC[31:28], bus.Ins[25:0], 2'b00};

  // Undefined encodings fall through to Result=0, newPC=nextPC.
  always_comb begin
    result_c = '0;
    new_pc_c = bus.nextPC;
    unique case (opcode)
      OP_RTYPE: begin
        unique case (funct)
          FN_ADD, FN_ADDU: result_c = a + b;
          FN_SUB, FN_SUBU: result_c = a - b;
          FN_AND:  result_c = a & b;
          FN_OR:   result_c = a | b;
          FN_XOR:  result_c = a ^ b;
          FN_NOR:  result_c = ~(a | b);
          FN_SLT:  result_c = {31'h0, $signed(a) < $signed(b)};
          FN_SLTU: result_c = {31'h0, a < b};
          FN_SLL:  result_c = b << shamt;
          FN_SRL:  result_c = b >> shamt;
          FN_SRA:  result_c = W'($signed(b) >>> shamt);
          FN_SLLV: result_c = b << a[4:0];
          FN_SRLV: result_c = b >> a[4:0];
          FN_SRAV: result_c = W'($signed(b) >>> a[4:0]);
          FN_JR:   new_pc_c = a;
          FN_JALR: begin
            result_c = bus.nextPC;
            new_pc_c = a;
          end
          default: result_c = '0;
        endcase
      end
      OP_ADDI, OP_ADDIU, OP_LW, OP_SW: result_c = a + imm;
      OP_SLTI:  result_c = {31'h0, $signed(a) < $signed(imm)};
      OP_SLTIU: result_c = {31'h0, a < imm};
      OP_ANDI:  result_c = a & zimm;
      OP_ORI:   result_c = a | zimm;
      OP_XORI:  result_c = a ^ zimm;
      OP_LUI:   result_c = {bus.Ed32[15:0], 16'h0};
      OP_BEQ: begin
        result_c = a - b;
        if (a == b) new_pc_c = br_target;
      end
      OP_BNE: begin
        result_c = a - b;
        if (a != b) new_pc_c = br_target;
      end
      OP_J:   new_pc_c = jmp_target;
      OP_JAL: begin
        result_c = bus.nextPC;
        new_pc_c = jmp_target;
      end
      default: result_c = '0;
    endcase
  end

  // Output register; reset clears both outputs immediately.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      bus.Result <= '0;
      bus.newPC  <= '0;
    end else begin
      bus.Result <= result_c;
      bus.newPC  <= new_pc_c;
    end
  end

endmodule

// File: tb/tb_mips_ex_stage.sv
// Self-checking bench for mips_ex_stage: directed cases plus random instructions against a reference model.
module tb_mips_ex_stage;

  logic CLK;
  logic RST;
  int   errors = 0;
  int   checks = 0;

  mips_ex_stage_if bus ();

  mips_ex_stage dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Reference: architectural meaning of each instruction, written from the ISA rules.
  function automatic void ref_model(input logic [31:0] ins, r1, r2, ed, npc,
                                    output logic [31:0] res, output logic [31:0] pc);
    logic [5:0]  op;
    logic [5:0]  fn;
    int unsigned sh;
    int unsigned shv;
    longint      s1, s2, se;
    op  = ins[31:26];
    fn  = ins[5:0];
    sh  = int'(ins[10:6]);
    shv = int'(r1[4:0]);
    s1  = longint'($signed(r1));
    s2  = longint'($signed(r2));
    se  = longint'($signed(ed));
    res = 32'h0;
    pc  = npc;
    if (op == 6'h00) begin
      case (fn)
        6'h20, 6'h21: res = r1 + r2;
        6'h22, 6'h23: res = r1 - r2;
        6'h24: res = r1 & r2;
        6'h25: res = r1 | r2;
        6'h26: res = r1 ^ r2;
        6'h27: res = ~(r1 | r2);
        6'h2A: res = (s1 < s2) ? 32'd1 : 32'd0;
        6'h2B: res = (longint'(r1) < longint'(r2)) ? 32'd1 : 32'd0;
        6'h00: res = 32'(longint'(r2) * (64'd1 << sh));
        6'h02: res = 32'(longint'(r2) / (64'd1 << sh));
        6'h03: res = 32'(s2 >>> sh);
        6'h04: res = 32'(longint'(r2) * (64'd1 << shv));
        6'h06: res = 32'(longint'(r2) / (64'd1 << shv));
        6'h07: res = 32'(s2 >>> shv);
        6'h08: pc = r1;
        6'h09: begin res = npc; pc = r1; end
        default: res = 32'h0;
      endcase
    end else begin
      case (op)
        6'h08, 6'h09, 6'h23, 6'h2B: res = 32'(longint'(r1) + se);
        6'h0A: res = (s1 < se) ? 32'd1 : 32'd0;
        6'h0B: res = (longint'(r1) < longint'(ed)) ? 32'd1 : 32'd0;
        6'h0C: res = r1 & (ed & 32'h0000FFFF);
        6'h0D: res = r1 | (ed & 32'h0000FFFF);
        6'h0E: res = r1 ^ (ed & 32'h0000FFFF);
        6'h0F: res = ed * 32'h10000;
        6'h04: begin res = r1 - r2; if (r1 == r2) pc = 32'(longint'(npc) + se * 4); end
        6'h05: begin res = r1 - r2; if (r1 != r2) pc = 32'(longint'(npc) + se * 4); end
        6'h02: pc = (npc & 32'hF000_0000) | ((ins & 32'h03FF_FFFF) * 4);
        6'h03: begin res = npc; pc = (npc & 32'hF000_0000) | ((ins & 32'h03FF_FFFF) * 4); end
        default: res = 32'h0;
      endcase
    end
  endfunction

  task automatic drive(input logic [31:0] ins, r1, r2, ed, npc);
    bus.Ins    = ins;
    bus.Rdata1 = r1;
    bus.Rdata2 = r2;
    bus.Ed32   = ed;
    bus.nextPC = npc;
  endtask

  // Directed case with hand-derived expectations, also cross-checked by the model.
  task automatic dir(input string tag, input logic [31:0] ins, r1, r2, ed, npc, eres, epc);
    logic [31:0] mres, mpc;
    drive(ins, r1, r2, ed, npc);
    @(posedge CLK);
    #1;
    check({tag, ".res"}, bus.Result, eres);
    check({tag, ".pc"}, bus.newPC, epc);
    ref_model(ins, r1, r2, ed, npc, mres, mpc);
    if (mres !== eres || mpc !== epc)
      $display("note: model disagrees on %s", tag);
  endtask

  task automatic rnd(input logic [31:0] ins, r1, r2, ed, npc);
    logic [31:0] mres, mpc;
    ref_model(ins, r1, r2, ed, npc, mres, mpc);
    drive(ins, r1, r2, ed, npc);
    @(posedge CLK);
    #1;
    check("rnd.res", bus.Result, mres);
    check("rnd.pc", bus.newPC, mpc);
  endtask

  function automatic logic [31:0] rand_ins();
    logic [5:0] ops [18];
    logic [5:0] fns [20];
    logic [31:0] w;
    ops = '{6'h00, 6'h00, 6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h09,
            6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h2B, 6'h3F};
    fns = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B,
            6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h08, 6'h09, 6'h01, 6'h3F};
    w = $urandom;
    w[31:26] = ($urandom_range(0, 9) == 0) ? 6'($urandom) : ops[$urandom_range(0, 17)];
    if (w[31:26] == 6'h00) w[5:0] = fns[$urandom_range(0, 19)];
    return w;
  endfunction

  initial begin
    logic [31:0] r1, r2, held_res, held_pc;
    RST = 1'b0;
    drive(32'h0000_0020, 32'd5, 32'd3, 32'd0, 32'h104);
    #12;
    check("rst.res", bus.Result, 32'h0);
    check("rst.pc", bus.newPC, 32'h0);
    @(negedge CLK);
    RST = 1'b1;
    @(posedge CLK);
    #1;
    check("rel.res", bus.Result, 32'd8);
    check("rel.pc", bus.newPC, 32'h104);

    dir("add",   32'h0000_0020, 32'd5, 32'd3, 32'd0, 32'h104, 32'd8, 32'h104);
    dir("sub",   32'h0000_0022, 32'd5, 32'd3, 32'd0, 32'h104, 32'd2, 32'h104);
    dir("and",   32'h0000_0024, 32'hF, 32'd3, 32'd0, 32'h104, 32'h3, 32'h104);
    dir("or",    32'h0000_0025, 32'hF, 32'd3, 32'd0, 32'h104, 32'hF, 32'h104);
    dir("xor",   32'h0000_0026, 32'hF, 32'd3, 32'd0, 32'h104, 32'hC, 32'h104);
    dir("slt",   32'h0000_002A, 32'd2, 32'd3, 32'd0, 32'h104, 32'd1, 32'h104);
    dir("sltu",  32'h0000_002B, 32'd2, 32'd3, 32'd0, 32'h104, 32'd1, 32'h104);
    dir("sltn",  32'h0000_002A, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'h104, 32'd1, 32'h104);
    dir("sltun", 32'h0000_002B, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'h104, 32'd0, 32'h104);
    dir("addi",  32'h2000_0003, 32'd5, 32'd0, 32'd2, 32'h104, 32'd7, 32'h104);
    dir("andi",  32'h3000_0003, 32'hF, 32'd0, 32'd3, 32'h104, 32'h3, 32'h104);
    dir("ori",   32'h3400_0003, 32'hF, 32'd0, 32'd3, 32'h104, 32'hF, 32'h104);
    dir("xori",  32'h3800_0003, 32'hF, 32'd0, 32'd3, 32'h104, 32'hC, 32'h104);
    dir("orizx", 32'h3400_0003, 32'd0, 32'd0, 32'hFFFF_8000, 32'h104, 32'h8000, 32'h104);
    dir("lui",   32'h3C00_0000, 32'd0, 32'd0, 32'h0000_ABCD, 32'h104, 32'hABCD_0000, 32'h104);
    dir("lw",    32'h8C00_0000, 32'h100, 32'd0, 32'hFFFF_FFFC, 32'h104, 32'hFC, 32'h104);
    dir("beqt",  32'h1000_0000, 32'd7, 32'd7, 32'd4, 32'h104, 32'd0, 32'h114);
    dir("beqn",  32'h1000_0000, 32'd7, 32'd5, 32'd4, 32'h104, 32'd2, 32'h104);
    dir("bnet",  32'h1400_0000, 32'd7, 32'd5, 32'd4, 32'h104, 32'd2, 32'h114);
    dir("j",     32'h0800_0040, 32'd0, 32'd0, 32'd0, 32'h104, 32'd0, 32'h100);
    dir("jal",   32'h0C00_0040, 32'd0, 32'd0, 32'd0, 32'h104, 32'h104, 32'h100);
    dir("jr",    32'h0000_0008, 32'h200, 32'd0, 32'd0, 32'h104, 32'd0, 32'h200);
    dir("jalr",  32'h0000_0009, 32'h200, 32'd0, 32'd0, 32'h104, 32'h104, 32'h200);
    dir("wrap",  32'h0000_0020, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'h104, 32'd0, 32'h104);
    dir("sra",   32'h0000_0103, 32'd0, 32'h8000_0000, 32'd0, 32'h104, 32'hF800_0000, 32'h104);
    dir("srl",   32'h0000_0102, 32'd0, 32'h8000_0000, 32'd0, 32'h104, 32'h0800_0000, 32'h104);
    dir("nop",   32'h0000_0000, 32'd9, 32'h1234_5678, 32'd0, 32'h104, 32'h1234_5678, 32'h104);
    dir("badop", 32'hFC00_0000, 32'd1, 32'd2, 32'd3, 32'h104, 32'd0, 32'h104);
    dir("badfn", 32'h0000_0001, 32'd1, 32'd2, 32'd3, 32'h104, 32'd0, 32'h104);

    // Outputs must hold while inputs change between edges.
    held_res = bus.Result;
    held_pc  = bus.newPC;
    drive(32'h0000_0020, 32'd100, 32'd23, 32'd0, 32'h500);
    #3;
    check("hold.res", bus.Result, held_res);
    check("hold.pc", bus.newPC, held_pc);

    for (int i = 0; i < 300; i++) begin
      r1 = $urandom;
      r2 = ($urandom_range(0, 3) == 0) ? r1 : $urandom;
      rnd(rand_ins(), r1, r2, $urandom, {$urandom} & 32'hFFFF_FFFC);
    end

    // Mid-stream reset discards the in-flight instruction.
    drive(32'h0000_0020, 32'd1, 32'd2, 32'd0, 32'h40);
    #2;
    RST = 1'b0;
    #1;
    check("mrst.res", bus.Result, 32'h0);
    check("mrst.pc", bus.newPC, 32'h0);
    @(negedge CLK);
    RST = 1'b1;
    @(posedge CLK);
    #1;
    check("mrel.res", bus.Result, 32'd3);
    check("mrel.pc", bus.newPC, 32'h40);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
